uart_rx_frame: RTL

- Serial receiver for the UART link: the counterpart of the transmit path that drives TxData/TxEn and returns TxDone.
- Samples the asynchronous Rx line and recovers 8N1 frames: 1 start bit, 8 data bits LSB first, 1 stop bit.
- Presents each received byte with a one-cycle RxDone strobe and a framing-error flag.
- Sits in TOP beside the transmitter and shares its clock and bit-period setting.

---
 rtl/uart_rx_frame.sv | 134 +++++++++++++
 1 files changed

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: 8N1 UART receiver with framing-error detect and break handling.
// Define UART_RX_PARITY_EN to add a parity bit (PARITY_ODD selects odd parity) and a ParityErr output.
module uart_rx_frame #(
  parameter int CLKS_PER_BIT = 5200,
  parameter int CNT_W        = 16
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit PARITY_ODD   = 1'b0
`endif
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Rx,
  output logic [7:0] RxData,
  output logic       RxDone,
  output logic       FrameErr,
  output logic       Busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic       ParityErr
`endif
);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(CLKS_PER_BIT - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK, PARITY} state_t;
  state_t           state_q, state_d;
  logic             s1_q, s2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d, data_q, data_d;
  logic             done_q, done_d, ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic             par_q, par_d, perr_q, perr_d;
`endif
  wire rx_s = s2_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = ferr_q;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = perr_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: if (cnt_q == HALF) begin
        cnt_d   = '0;
        idx_d   = '0;
        state_d = rx_s ? IDLE : DATA;
      end
      DATA: if (cnt_q == FULL) begin
        cnt_d   = '0;
        shift_d = {rx_s, shift_q[7:1]};
        idx_d   = idx_q + 3'd1;
`ifdef UART_RX_PARITY_EN
        if (idx_q == 3'd7) state_d = PARITY;
`else
        if (idx_q == 3'd7) state_d = STOP;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (cnt_q == FULL) begin
        cnt_d   = '0;
        par_d   = ^shift_q ^ rx_s ^ PARITY_ODD;
        state_d = STOP;
      end
`endif
      // Leave at mid-stop-bit so a start bit right after the stop bit is not missed
      STOP: if (cnt_q == FULL) begin
        cnt_d   = '0;
        done_d  = 1'b1;
        data_d  = shift_q;
        ferr_d  = ~rx_s;
`ifdef UART_RX_PARITY_EN
        perr_d  = par_q;
`endif
        state_d = rx_s ? IDLE : BREAK;
      end
      BREAK: begin
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      s1_q    <= Rx;
      s2_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end
  assign RxData   = data_q;
  assign RxDone   = done_q;
  assign FrameErr = ferr_q;
  assign Busy     = state_q != IDLE;
`ifdef UART_RX_PARITY_EN
  assign ParityErr = perr_q;
`endif
endmodule
